// File: rtl/ddr_frame_scheduler.sv
// rtl/ddr_frame_scheduler.sv - round-robin DMA command scheduler for the C2H/H2C frame rings
module ddr_frame_scheduler #(
  parameter logic [31:0] C2H_START     = 32'h0000_0000,
  parameter logic [31:0] C2H_END       = 32'h1000_0000,
  parameter logic [31:0] C2H_BUF_SIZE  = 32'd2048,
  parameter logic [31:0] C2H_FRM_SIZE  = 32'd2048,
  parameter logic [31:0] H2C_BUF_START = 32'h1000_0000,
  parameter logic [31:0] H2C_BUF_END   = 32'h2000_0000,
  parameter logic [31:0] H2C_BUF_SIZE  = 32'd2048
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_aresetn,
  input  logic        c2h_req,
  output logic        c2h_ack,
  input  logic [31:0] c2h_rd_next,
  output logic [31:0] c2h_wr_next,
  output logic        c2h_full,
  input  logic [31:0] h2c_wr_next,
  input  logic [31:0] h2c_frm_size,
  output logic [31:0] h2c_rd_next,
  output logic        h2c_empty,
  output logic        h2c_ack,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_write,
  output logic [31:0] cmd_addr,
  output logic [31:0] cmd_len,
  input  logic        cmd_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t      state;
  logic        last_grant_h2c;
  logic        c2h_elig;
  logic        h2c_elig;
  logic        grant_c2h;
  logic [31:0] c2h_wr_succ;
  logic [31:0] h2c_rd_succ;
  logic [31:0] h2c_len;

  // Sum kept at 33 bits so a slot near 4 GiB cannot wrap past the region end.
  function automatic logic [31:0] nxt(input logic [31:0] p, input logic [31:0] start,
                                      input logic [31:0] stop, input logic [31:0] size);
    logic [32:0] sum;
    sum = {1'b0, p} + {1'b0, size};
    return (sum >= {1'b0, stop}) ? start : sum[31:0];
  endfunction

  assign c2h_wr_succ = nxt(c2h_wr_next, C2H_START, C2H_END, C2H_BUF_SIZE);
  assign h2c_rd_succ = nxt(h2c_rd_next, H2C_BUF_START, H2C_BUF_END, H2C_BUF_SIZE);

  assign c2h_full  = (c2h_wr_succ == c2h_rd_next);
  assign h2c_empty = (h2c_rd_next == h2c_wr_next);
  assign c2h_elig  = c2h_req && !c2h_full;
  assign h2c_elig  = !h2c_empty;
  assign grant_c2h = c2h_elig && (!h2c_elig || last_grant_h2c);

  always_comb begin
    h2c_len = h2c_frm_size;
    if (h2c_frm_size == 32'd0 || h2c_frm_size > H2C_BUF_SIZE)
      h2c_len = H2C_BUF_SIZE;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state          <= IDLE;
      last_grant_h2c <= 1'b1;
      c2h_wr_next    <= C2H_START;
      h2c_rd_next    <= H2C_BUF_START;
      cmd_valid      <= 1'b0;
      cmd_write      <= 1'b0;
      cmd_addr       <= 32'd0;
      cmd_len        <= 32'd0;
      c2h_ack        <= 1'b0;
      h2c_ack        <= 1'b0;
    end else begin
      c2h_ack <= 1'b0;
      h2c_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (c2h_elig || h2c_elig) begin
            cmd_valid <= 1'b1;
            cmd_write <= grant_c2h;
            cmd_addr  <= grant_c2h ? c2h_wr_next : h2c_rd_next;
            cmd_len   <= grant_c2h ? C2H_FRM_SIZE : h2c_len;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // cmd_write still identifies which side owns the outstanding command.
          if (cmd_done) begin
            if (cmd_write) begin
              c2h_wr_next <= c2h_wr_succ;
              c2h_ack     <= 1'b1;
            end else begin
              h2c_rd_next <= h2c_rd_succ;
              h2c_ack     <= 1'b1;
            end
            last_grant_h2c <= !cmd_write;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_frame_scheduler.sv
// tb/tb_ddr_frame_scheduler.sv - model-checked bench for ddr_frame_scheduler
module tb_ddr_frame_scheduler;

  localparam logic [31:0] C2H_START = 32'h0000;
  localparam logic [31:0] C2H_END   = 32'h2000;
  localparam logic [31:0] H2C_START = 32'h2000;
  localparam logic [31:0] H2C_END   = 32'h4000;
  localparam logic [31:0] SLOT      = 32'd2048;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn;
  logic        c2h_req, c2h_ack, c2h_full, h2c_empty, h2c_ack;
  logic [31:0] c2h_rd_next, c2h_wr_next, h2c_wr_next, h2c_frm_size, h2c_rd_next;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_done;
  logic [31:0] cmd_addr, cmd_len;

  int checks = 0;
  int errors = 0;

  always #5 s_axi_aclk = ~s_axi_aclk;

  ddr_frame_scheduler #(
    .C2H_START(C2H_START), .C2H_END(C2H_END), .C2H_BUF_SIZE(SLOT), .C2H_FRM_SIZE(SLOT),
    .H2C_BUF_START(H2C_START), .H2C_BUF_END(H2C_END), .H2C_BUF_SIZE(SLOT)
  ) dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .c2h_req(c2h_req), .c2h_ack(c2h_ack), .c2h_rd_next(c2h_rd_next),
    .c2h_wr_next(c2h_wr_next), .c2h_full(c2h_full),
    .h2c_wr_next(h2c_wr_next), .h2c_frm_size(h2c_frm_size), .h2c_rd_next(h2c_rd_next),
    .h2c_empty(h2c_empty), .h2c_ack(h2c_ack),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done)
  );

  function automatic logic [31:0] ring_next(input logic [31:0] p, input logic [31:0] lo,
                                            input logic [31:0] hi);
    longint unsigned s;
    s = longint'(p) + longint'(SLOT);
    return (s >= longint'(hi)) ? lo : p + SLOT;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one outstanding command, fields frozen at grant.
  logic [31:0] m_c2h_wr, m_h2c_rd, m_addr, m_len;
  logic        m_valid, m_busy, m_write, m_last_h2c, m_ack_c, m_ack_h;
  logic        m_ce, m_he, m_pick_c;
  logic [31:0] m_h2c_len;

  assign m_ce      = c2h_req && (ring_next(m_c2h_wr, C2H_START, C2H_END) != c2h_rd_next);
  assign m_he      = (m_h2c_rd != h2c_wr_next);
  assign m_pick_c  = m_ce && (!m_he || m_last_h2c);
  assign m_h2c_len = (h2c_frm_size == 0 || h2c_frm_size > SLOT) ? SLOT : h2c_frm_size;

  always @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      m_c2h_wr <= C2H_START; m_h2c_rd <= H2C_START;
      m_addr <= 0; m_len <= 0; m_valid <= 0; m_busy <= 0; m_write <= 0;
      m_last_h2c <= 1; m_ack_c <= 0; m_ack_h <= 0;
    end else begin
      m_ack_c <= 0;
      m_ack_h <= 0;
      if (m_valid) begin
        if (cmd_ready) begin m_valid <= 0; m_busy <= 1; end
      end else if (m_busy) begin
        if (cmd_done) begin
          m_busy <= 0;
          m_last_h2c <= !m_write;
          if (m_write) begin m_c2h_wr <= ring_next(m_c2h_wr, C2H_START, C2H_END); m_ack_c <= 1; end
          else begin m_h2c_rd <= ring_next(m_h2c_rd, H2C_START, H2C_END); m_ack_h <= 1; end
        end
      end else if (m_ce || m_he) begin
        m_valid <= 1;
        m_write <= m_pick_c;
        m_addr  <= m_pick_c ? m_c2h_wr : m_h2c_rd;
        m_len   <= m_pick_c ? SLOT : m_h2c_len;
      end
    end
  end

  always @(negedge s_axi_aclk) begin
    if (s_axi_aresetn) begin
      check("m_cmd_valid", cmd_valid, m_valid);
      check("m_cmd_write", cmd_write, m_write);
      check("m_cmd_addr", cmd_addr, m_addr);
      check("m_cmd_len", cmd_len, m_len);
      check("m_c2h_wr_next", c2h_wr_next, m_c2h_wr);
      check("m_h2c_rd_next", h2c_rd_next, m_h2c_rd);
      check("m_c2h_ack", c2h_ack, m_ack_c);
      check("m_h2c_ack", h2c_ack, m_ack_h);
      check("m_c2h_full", c2h_full, ring_next(m_c2h_wr, C2H_START, C2H_END) == c2h_rd_next);
      check("m_h2c_empty", h2c_empty, m_h2c_rd == h2c_wr_next);
    end
  end

  task automatic step();
    @(negedge s_axi_aclk);
    #1;
  endtask

  // Wait for a command, check its fields, stall ready, handshake, then complete it.
  task automatic do_cmd(input logic exp_w, input logic [31:0] exp_a, input logic [31:0] exp_l,
                        input int stall, input int done_dly);
    int n = 0;
    while (!cmd_valid && n < 50) begin step(); n++; end
    check("cmd_valid_arrives", cmd_valid, 1'b1);
    check("cmd_write", cmd_write, exp_w);
    check("cmd_addr", cmd_addr, exp_a);
    check("cmd_len", cmd_len, exp_l);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_valid", cmd_valid, 1'b1);
      check("stall_addr", cmd_addr, exp_a);
    end
    cmd_ready = 1; step(); cmd_ready = 0;
    for (int i = 1; i < done_dly; i++) step();
    cmd_done = 1; step(); cmd_done = 0;
    check("ack_pulse", exp_w ? c2h_ack : h2c_ack, 1'b1);
  endtask

  initial begin
    s_axi_aresetn = 0; c2h_req = 0; c2h_rd_next = 0; h2c_wr_next = H2C_START;
    h2c_frm_size = SLOT; cmd_ready = 0; cmd_done = 0;
    repeat (3) step();
    check("rst_c2h_wr_next", c2h_wr_next, 32'h0);
    check("rst_h2c_rd_next", h2c_rd_next, 32'h2000);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_h2c_empty", h2c_empty, 1'b1);
    check("rst_c2h_full", c2h_full, 1'b0);
    s_axi_aresetn = 1;
    step();

    // C2H single write, then fill to full and wrap.
    c2h_req = 1;
    do_cmd(1, 32'h0, 32'd2048, 0, 3);
    check("c2h_wr_after_1", c2h_wr_next, 32'h800);
    do_cmd(1, 32'h800, 32'd2048, 0, 2);
    do_cmd(1, 32'h1000, 32'd2048, 0, 2);
    repeat (4) step();
    check("c2h_full_set", c2h_full, 1'b1);
    check("c2h_full_no_cmd", cmd_valid, 1'b0);
    c2h_rd_next = 32'h800;
    do_cmd(1, 32'h1800, 32'd2048, 0, 2);
    check("c2h_wrap", c2h_wr_next, 32'h0);
    c2h_req = 0;

    // H2C clamp, zero size, and an in-range size.
    h2c_wr_next = 32'h2800; h2c_frm_size = 32'd5000;
    do_cmd(0, 32'h2000, 32'd2048, 0, 2);
    check("h2c_rd_adv", h2c_rd_next, 32'h2800);
    check("h2c_empty_after", h2c_empty, 1'b1);
    h2c_wr_next = 32'h3000; h2c_frm_size = 32'd0;
    do_cmd(0, 32'h2800, 32'd2048, 0, 1);
    h2c_wr_next = 32'h3800; h2c_frm_size = 32'd100;
    do_cmd(0, 32'h3000, 32'd100, 0, 1);

    // Round-robin with both sides eligible; last grant was H2C so C2H leads.
    c2h_rd_next = 32'h1800; h2c_wr_next = 32'h3000; h2c_frm_size = SLOT; c2h_req = 1;
    do_cmd(1, 32'h0, 32'd2048, 0, 1);
    do_cmd(0, 32'h3800, 32'd2048, 0, 1);
    do_cmd(1, 32'h800, 32'd2048, 5, 1);
    do_cmd(0, 32'h2000, 32'd2048, 0, 1);
    c2h_req = 0; h2c_wr_next = 32'h2800;
    step();

    // Reset during WAIT_DONE, then a late cmd_done.
    h2c_wr_next = 32'h3000;
    begin
      int n = 0;
      while (!cmd_valid && n < 20) begin step(); n++; end
    end
    check("rst_test_valid", cmd_valid, 1'b1);
    cmd_ready = 1; step(); cmd_ready = 0; step();
    s_axi_aresetn = 0; h2c_wr_next = H2C_START; c2h_rd_next = 0;
    #1;
    check("midrst_cmd_valid", cmd_valid, 1'b0);
    check("midrst_c2h_wr", c2h_wr_next, 32'h0);
    check("midrst_h2c_rd", h2c_rd_next, 32'h2000);
    step(); s_axi_aresetn = 1; step();
    cmd_done = 1; step(); cmd_done = 0;
    check("late_done_c2h_ack", c2h_ack, 1'b0);
    check("late_done_h2c_ack", h2c_ack, 1'b0);
    check("late_done_h2c_rd", h2c_rd_next, 32'h2000);
    check("late_done_valid", cmd_valid, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      step();
      c2h_req   = ($urandom_range(0, 3) != 0);
      cmd_ready = ($urandom_range(0, 2) == 0);
      cmd_done  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) c2h_rd_next = 32'h800 * $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) h2c_wr_next = H2C_START + 32'h800 * $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: h2c_frm_size = 0;
        1: h2c_frm_size = SLOT;
        2: h2c_frm_size = SLOT + 1;
        3: h2c_frm_size = $urandom_range(1, 2047);
        default: h2c_frm_size = $urandom;
      endcase
      s_axi_aresetn = ($urandom_range(0, 599) != 0);
    end
    s_axi_aresetn = 1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
